// File: rtl/channel_host.sv
// Host-side UART initiator: sends one 8N1 request byte on line_tx, then receives a
// single-byte reply on line_rx and reports it as done, timeout or framing error.
module channel_host #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       line_tx,
  input  logic       line_rx,
  output logic       busy,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       rsp_err
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [TW-1:0]   to_q, to_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            tx_q, tx_d;
  logic            vld_q, vld_d, tmo_q, tmo_d, err_q, err_d;
  logic [1:0]      sync_q;
  logic            rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      to_q       <= '0;
      idx_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rsp_data_q <= '0;
      tx_q       <= 1'b1;
      vld_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      to_q       <= to_d;
      idx_q      <= idx_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rsp_data_q <= rsp_data_d;
      tx_q       <= tx_d;
      vld_q      <= vld_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      sync_q     <= {sync_q[0], line_rx};
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    to_d       = to_q;
    idx_d      = idx_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rsp_data_d = rsp_data_q;
    tx_d       = tx_q;
    vld_d      = 1'b0;
    tmo_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (req_valid) begin
          tx_sh_d = req_data;
          tx_d    = 1'b0;
          baud_d  = '0;
          idx_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = tx_sh_q[0];
          state_d = TX_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      TX_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = tx_sh_q[idx_q + 3'd1];
          end
        end else baud_d = baud_q + 1'b1;
      end
      TX_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          to_d    = '0;
          state_d = RX_WAIT;
        end else baud_d = baud_q + 1'b1;
      end
      RX_WAIT: begin
        if (!rx_s) begin
          baud_d  = '0;
          state_d = RX_START;
        end else if (to_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else to_d = to_q + 1'b1;
      end
      // Timeout counter holds while qualifying a start bit; a false start resumes it.
      RX_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_WAIT : RX_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      RX_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          rx_sh_d = {rx_s, rx_sh_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else idx_d = idx_q + 3'd1;
        end else baud_d = baud_q + 1'b1;
      end
      RX_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s) begin
            vld_d      = 1'b1;
            rsp_data_d = rx_sh_q;
          end else err_d = 1'b1;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign line_tx     = tx_q | reset;
  assign rsp_valid   = vld_q;
  assign rsp_timeout = tmo_q;
  assign rsp_err     = err_q;
  assign rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_channel_host.sv
// Self-checking bench for channel_host: random request/reply bytes checked against a
// frame-level model of the 8N1 line protocol and the status latency rules.
module tb_channel_host;
  localparam int CBP = 8;
  localparam int TMO = 400;
  localparam int LAT = 2 + CBP/2 + 9*CBP + 1;

  logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0, line_rx = 1'b1;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, line_tx, busy, rsp_valid, rsp_timeout, rsp_err;
  logic [7:0] rsp_data;

  int checks = 0, errors = 0;
  int n_vld = 0, n_tmo = 0, n_err = 0;
  logic [7:0] exp_data = 8'h00;

  channel_host #(.CLKS_PER_BIT(CBP), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .line_tx(line_tx), .line_rx(line_rx), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_vld += int'(rsp_valid);
    n_tmo += int'(rsp_timeout);
    n_err += int'(rsp_err);
  end

  // 8N1 frame in transmission order: start 0, data LSB first, stop 1.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int k = 0; k < 10; k++)
      f[k] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    return f;
  endfunction

  task automatic send_req(input logic [7:0] b);
    req_valid = 1'b1;
    req_data  = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = 8'($urandom);
  endtask

  task automatic capture_frame(output logic [9:0] bits, output int hold_bad, output int busy_bad);
    bits = '0; hold_bad = 0; busy_bad = 0;
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CBP; c++) begin
        @(negedge clk);
        if (c == 0) bits[k] = line_tx;
        else if (line_tx !== bits[k]) hold_bad++;
        if (busy !== 1'b1 || req_ready !== 1'b0) busy_bad++;
      end
  endtask

  task automatic drive_reply(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = exp_frame(d);
    f[9] = stop;
    for (int k = 0; k < 10; k++) begin
      line_rx = f[k];
      repeat (CBP) @(posedge clk);
      #1;
    end
    line_rx = 1'b1;
  endtask

  // kind: 0 none, 1 valid, 2 timeout, 3 framing error
  task automatic wait_status(input int bound, output int lat, output int kind, output int busy_bad);
    lat = 0; kind = 0; busy_bad = 0;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || rsp_timeout || rsp_err) begin
        lat = k;
        kind = rsp_valid ? 1 : rsp_timeout ? 2 : 3;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic serve_reply(input logic [7:0] d, input logic stop, input int gap,
                             output int lat, output int kind, output int busy_bad);
    @(posedge clk);
    repeat (gap) @(posedge clk);
    #1;
    fork
      drive_reply(d, stop);
    join_none
    wait_status(LAT + 40, lat, kind, busy_bad);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send_req(8'($urandom));
    repeat (3) @(posedge clk);
    #($urandom_range(1, 8));
    reset = 1'b1;
    #1;
    checks++; if (line_tx !== 1'b1) begin errors++; $display("FAIL reset_line_tx got %b exp 1", line_tx); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy got %b%b exp 10", req_ready, busy); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rsp_valid, rsp_timeout, rsp_err}); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    begin
      int bad = 0;
      repeat (3) @(negedge clk) if (line_tx !== 1'b1) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold_line_tx low_cycles %0d exp 0", bad); end
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_data = 8'h00;
  endtask

  task automatic test_tx_frame;
    logic [9:0] bits; int hb, bb, lat, kind, wb, v0, t0, e0;
    logic [7:0] r;
    v0 = n_vld; t0 = n_tmo; e0 = n_err;
    r = 8'($urandom);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_idle got %b exp 1", req_ready); end
    send_req(8'hA5);
    req_valid = 1'b1; req_data = 8'h5A;     // held while busy: must be ignored
    capture_frame(bits, hb, bb);
    req_valid = 1'b0;
    checks++; if (bits !== exp_frame(8'hA5)) begin errors++; $display("FAIL tx_a5_bits got %b exp %b", bits, exp_frame(8'hA5)); end
    checks++; if (hb != 0) begin errors++; $display("FAIL tx_a5_hold bad_cycles %0d exp 0", hb); end
    checks++; if (bb != 0) begin errors++; $display("FAIL tx_a5_busy_ready bad_cycles %0d exp 0", bb); end
    serve_reply(r, 1'b1, 10, lat, kind, wb);
    exp_data = r;
    checks++; if (kind != 1 || lat != LAT) begin errors++; $display("FAIL tx_reply kind %0d lat %0d exp 1 %0d", kind, lat, LAT); end
    checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL tx_reply_data got %h exp %h", rsp_data, exp_data); end
    checks++; if (wb != 0) begin errors++; $display("FAIL tx_wait_busy low_cycles %0d exp 0", wb); end
    repeat (2) @(negedge clk);
    checks++; if (n_vld - v0 != 1 || n_tmo != t0 || n_err != e0) begin errors++; $display("FAIL tx_pulse_count vld %0d tmo %0d err %0d exp 1 0 0", n_vld - v0, n_tmo - t0, n_err - e0); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits; int hb, bb, lat, kind, wb, v0, t0, e0;
    logic [7:0] a, b, c;
    v0 = n_vld; t0 = n_tmo; e0 = n_err;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    send_req(a);
    capture_frame(bits, hb, bb);
    checks++; if (bits !== exp_frame(a) || hb != 0) begin errors++; $display("FAIL b2b_first_frame got %b exp %b hold %0d", bits, exp_frame(a), hb); end
    serve_reply(8'h3C, 1'b1, 50, lat, kind, wb);
    exp_data = 8'h3C;
    checks++; if (kind != 1 || lat != LAT) begin errors++; $display("FAIL b2b_3c kind %0d lat %0d exp 1 %0d", kind, lat, LAT); end
    checks++; if (rsp_data !== 8'h3C) begin errors++; $display("FAIL b2b_3c_data got %h exp 3c", rsp_data); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
    send_req(b);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept valid %b busy %b exp 0 1", rsp_valid, busy); end
    capture_frame(bits, hb, bb);
    checks++; if (bits !== exp_frame(b) || hb != 0 || bb != 0) begin errors++; $display("FAIL b2b_second_frame got %b exp %b hold %0d busy %0d", bits, exp_frame(b), hb, bb); end
    serve_reply(c, 1'b1, 5, lat, kind, wb);
    exp_data = c;
    checks++; if (kind != 1 || rsp_data !== c) begin errors++; $display("FAIL b2b_second_reply kind %0d data %h exp 1 %h", kind, rsp_data, c); end
    repeat (2) @(negedge clk);
    checks++; if (n_vld - v0 != 2 || n_tmo != t0 || n_err != e0) begin errors++; $display("FAIL b2b_pulse_count vld %0d tmo %0d err %0d exp 2 0 0", n_vld - v0, n_tmo - t0, n_err - e0); end
  endtask

  task automatic test_timeout;
    logic [9:0] bits; int hb, bb, lat, kind, wb, v0, t0, e0;
    v0 = n_vld; t0 = n_tmo; e0 = n_err;
    send_req(8'($urandom));
    capture_frame(bits, hb, bb);
    @(posedge clk);                      // RX_WAIT entry edge
    wait_status(TMO + 20, lat, kind, wb);
    checks++; if (kind != 2 || lat != TMO) begin errors++; $display("FAIL timeout kind %0d lat %0d exp 2 %0d", kind, lat, TMO); end
    checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL timeout_data got %h exp %h", rsp_data, exp_data); end
    checks++; if (wb != 0) begin errors++; $display("FAIL timeout_busy low_cycles %0d exp 0", wb); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle busy %b ready %b exp 0 1", busy, req_ready); end
    @(negedge clk);
    checks++; if (n_tmo - t0 != 1 || n_vld != v0 || n_err != e0) begin errors++; $display("FAIL timeout_pulse_count vld %0d tmo %0d err %0d exp 0 1 0", n_vld - v0, n_tmo - t0, n_err - e0); end
  endtask

  task automatic test_false_start_and_err;
    logic [9:0] bits; int hb, bb, lat, kind, wb, v0, t0, e0;
    v0 = n_vld; t0 = n_tmo; e0 = n_err;
    send_req(8'($urandom));
    capture_frame(bits, hb, bb);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1 line_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 line_rx = 1'b1;
    serve_reply(8'h81, 1'b1, 30, lat, kind, wb);
    exp_data = 8'h81;
    checks++; if (kind != 1 || lat != LAT) begin errors++; $display("FAIL glitch_reply kind %0d lat %0d exp 1 %0d", kind, lat, LAT); end
    checks++; if (rsp_data !== 8'h81) begin errors++; $display("FAIL glitch_reply_data got %h exp 81", rsp_data); end
    send_req(8'($urandom));
    capture_frame(bits, hb, bb);
    serve_reply(8'($urandom), 1'b0, 15, lat, kind, wb);
    checks++; if (kind != 3 || lat != LAT) begin errors++; $display("FAIL stop_err kind %0d lat %0d exp 3 %0d", kind, lat, LAT); end
    checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL stop_err_data got %h exp %h", rsp_data, exp_data); end
    repeat (4) @(negedge clk);
    checks++; if (n_vld - v0 != 1 || n_tmo != t0 || n_err - e0 != 1) begin errors++; $display("FAIL fs_pulse_count vld %0d tmo %0d err %0d exp 1 0 1", n_vld - v0, n_tmo - t0, n_err - e0); end
  endtask

  task automatic test_random;
    logic [9:0] bits; int hb, bb, lat, kind, wb;
    logic [7:0] b, r; logic stop;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom); r = 8'($urandom);
      stop = 1'($urandom_range(0, 1));
      send_req(b);
      capture_frame(bits, hb, bb);
      checks++; if (bits !== exp_frame(b) || hb != 0 || bb != 0) begin errors++; $display("FAIL rand_frame[%0d] got %b exp %b hold %0d busy %0d", i, bits, exp_frame(b), hb, bb); end
      serve_reply(r, stop, $urandom_range(0, 60), lat, kind, wb);
      if (stop) exp_data = r;
      checks++; if (kind != (stop ? 1 : 3) || lat != LAT || rsp_data !== exp_data) begin errors++; $display("FAIL rand_reply[%0d] kind %0d lat %0d data %h exp %0d %0d %h", i, kind, lat, rsp_data, stop ? 1 : 3, LAT, exp_data); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_tx;
    int v0, t0, e0, bad;
    v0 = n_vld; t0 = n_tmo; e0 = n_err;
    send_req(8'hFF);
    repeat (42) @(posedge clk);          // inside data bit 4
    #($urandom_range(1, 8));
    reset = 1'b1;
    #1;
    checks++; if (line_tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midtx_reset line_tx %b busy %b exp 1 0", line_tx, busy); end
    bad = 0;
    repeat (3) @(negedge clk) if (line_tx !== 1'b1) bad++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midtx_ready ready %b busy %b exp 1 0", req_ready, busy); end
    repeat (100) @(negedge clk) if (line_tx !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL midtx_line_high low_cycles %0d exp 0", bad); end
    checks++; if (n_vld != v0 || n_tmo != t0 || n_err != e0) begin errors++; $display("FAIL midtx_no_pulse vld %0d tmo %0d err %0d exp 0 0 0", n_vld - v0, n_tmo - t0, n_err - e0); end
    exp_data = 8'h00;
    checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL midtx_data got %h exp %h", rsp_data, exp_data); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_timeout();
    test_false_start_and_err();
    test_random();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
